// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin front end for a byte-wide UART transmitter.
// Issues one byte per handshake, then tracks the transmitter's busy flag with a start timeout.
module uart_tx_arbiter #(
   parameter int         BUSY_TIMEOUT = 16,
   parameter logic [2:0] BAUD_RESET   = 3'd7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   input  logic [2:0] baud_cfg,
   input  logic       baud_cfg_wr,
   input  logic       clear_err,
   input  logic       Tx_BUSY,
   output logic [7:0] Tx_DATA,
   output logic       Tx_WR,
   output logic       Tx_EN,
   output logic [2:0] baud_select,
   output logic       grant,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ISSUE      = 2'd1,
      WAIT_START = 2'd2,
      WAIT_END   = 2'd3
   } state_t;

   localparam logic [4:0] TIMEOUT_CNT = 5'(BUSY_TIMEOUT);

   state_t     state_q, state_d;
   logic [4:0] cnt_q, cnt_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic       tx_wr_q, tx_wr_d;
   logic       ack0_q, ack0_d;
   logic       ack1_q, ack1_d;
   logic       tx_en_q, tx_en_d;
   logic [2:0] baud_q, baud_d;
   logic       grant_q, grant_d;
   logic       busy_q, busy_d;
   logic       err_q, err_d;

   logic       arb_go;
   logic       winner;
   logic [4:0] cnt_inc;

   always_comb begin
      // On a tie the requester that did not win last time goes next.
      winner  = (req0 & req1) ? ~grant_q : ~req0;
      arb_go  = (state_q == IDLE) & enable & ~Tx_BUSY & (req0 | req1);
      cnt_inc = cnt_q + 5'd1;

      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_data_d = tx_data_q;
      tx_wr_d   = 1'b0;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      tx_en_d   = enable;
      baud_d    = baud_q;
      grant_d   = grant_q;
      err_d     = err_q & ~clear_err;

      case (state_q)
         IDLE: begin
            if (arb_go) begin
               state_d   = ISSUE;
               tx_data_d = winner ? data1 : data0;
               tx_wr_d   = 1'b1;
               ack0_d    = ~winner;
               ack1_d    = winner;
               grant_d   = winner;
            end else if (baud_cfg_wr) begin
               baud_d = baud_cfg;
            end
         end
         ISSUE: begin
            state_d = WAIT_START;
            cnt_d   = 5'd0;
         end
         WAIT_START: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = 5'd0;
            end else if (Tx_BUSY) begin
               state_d = WAIT_END;
               cnt_d   = 5'd0;
            end else if (cnt_inc == TIMEOUT_CNT) begin
               // Set has priority over a simultaneous clear_err.
               err_d   = 1'b1;
               state_d = IDLE;
               cnt_d   = 5'd0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_END: begin
            if (!enable || !Tx_BUSY) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 5'd0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         tx_data_q <= 8'h00;
         tx_wr_q   <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         tx_en_q   <= 1'b0;
         baud_q    <= BAUD_RESET;
         grant_q   <= 1'b1;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         tx_wr_q   <= tx_wr_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         tx_en_q   <= tx_en_d;
         baud_q    <= baud_d;
         grant_q   <= grant_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   assign Tx_DATA     = tx_data_q;
   assign Tx_WR       = tx_wr_q;
   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign Tx_EN       = tx_en_q;
   assign baud_select = baud_q;
   assign grant       = grant_q;
   assign busy        = busy_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenarios plus a randomized run scored against a transaction-timing model.
module tb_uart_tx_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [7:0] data0 = 8'h00;
   logic [7:0] data1 = 8'h00;
   logic [2:0] baud_cfg = 3'd0;
   logic       baud_cfg_wr = 1'b0;
   logic       clear_err = 1'b0;
   logic       Tx_BUSY = 1'b0;
   logic       ack0, ack1, Tx_WR, Tx_EN, grant, busy, timeout_err;
   logic [7:0] Tx_DATA;
   logic [2:0] baud_select;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.BUSY_TIMEOUT(16), .BAUD_RESET(3'd7)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .req0(req0), .req1(req1), .data0(data0), .data1(data1),
      .ack0(ack0), .ack1(ack1),
      .baud_cfg(baud_cfg), .baud_cfg_wr(baud_cfg_wr), .clear_err(clear_err),
      .Tx_BUSY(Tx_BUSY), .Tx_DATA(Tx_DATA), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN),
      .baud_select(baud_select), .grant(grant), .busy(busy), .timeout_err(timeout_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; enable = 1'b1; req0 = 1'b0; req1 = 1'b0;
      data0 = 8'h00; data1 = 8'h00; Tx_BUSY = 1'b0;
      baud_cfg_wr = 1'b0; clear_err = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_wr"},    32'(Tx_WR), 0);
      check_eq({tag, "_ack0"},  32'(ack0), 0);
      check_eq({tag, "_ack1"},  32'(ack1), 0);
      check_eq({tag, "_data"},  32'(Tx_DATA), 0);
      check_eq({tag, "_txen"},  32'(Tx_EN), 0);
      check_eq({tag, "_baud"},  32'(baud_select), 7);
      check_eq({tag, "_grant"}, 32'(grant), 1);
      check_eq({tag, "_busy"},  32'(busy), 0);
      check_eq({tag, "_err"},   32'(timeout_err), 0);
   endtask

   // Expected outputs come from issue times and transmitter busy windows, not from FSM states.
   task automatic run_random(input int ncyc);
      int         idle_from, bs, be, err_set, w, d, len;
      logic       e_wr, e_a0, e_a1, e_grant, e_busy, e_err, e_txen, arb, win, clr, bwr;
      logic [7:0] e_data;
      logic [2:0] e_baud, bcfg;
      do_reset();
      e_wr = 0; e_a0 = 0; e_a1 = 0; e_grant = 1; e_busy = 0; e_err = 0; e_txen = 0;
      e_data = 8'h00; e_baud = 3'd7;
      idle_from = 0; bs = -1; be = -1; err_set = -1; w = -1;
      for (int n = 0; n < ncyc; n++) begin
         if (n > 0) tick();
         check_eq("r_wr",    32'(Tx_WR), 32'(e_wr));
         check_eq("r_ack0",  32'(ack0), 32'(e_a0));
         check_eq("r_ack1",  32'(ack1), 32'(e_a1));
         check_eq("r_grant", 32'(grant), 32'(e_grant));
         check_eq("r_data",  32'(Tx_DATA), 32'(e_data));
         check_eq("r_busy",  32'(busy), 32'(e_busy));
         check_eq("r_err",   32'(timeout_err), 32'(e_err));
         check_eq("r_baud",  32'(baud_select), 32'(e_baud));
         check_eq("r_txen",  32'(Tx_EN), 32'(e_txen));

         if (n == w) begin
            if (e_a0) req0 = 1'b0;
            else      req1 = 1'b0;
         end
         if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; data0 = 8'($urandom); end
         if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; data1 = 8'($urandom); end
         Tx_BUSY = (n >= bs && n < be);
         clr = ($urandom_range(0, 19) == 0);
         clear_err = clr;
         bcfg = 3'($urandom);
         bwr = ($urandom_range(0, 4) == 0);
         baud_cfg = bcfg;
         baud_cfg_wr = bwr;

         arb = (n >= idle_from) && !Tx_BUSY && (req0 || req1);
         e_wr = arb; e_a0 = 0; e_a1 = 0;
         e_err = (n == err_set) ? 1'b1 : (clr ? 1'b0 : e_err);
         if (n >= idle_from && !arb && bwr) e_baud = bcfg;
         if (arb) begin
            if (req0 && req1) win = (e_grant == 1'b1) ? 1'b0 : 1'b1;
            else              win = req1;
            e_a0 = !win; e_a1 = win; e_grant = win;
            e_data = win ? data1 : data0;
            w = n + 1;
            if ($urandom_range(0, 5) == 0) begin
               err_set = w + 16; idle_from = w + 17; bs = -1; be = -1;
            end else begin
               d = $urandom_range(1, 16); len = $urandom_range(1, 6);
               bs = w + d; be = w + d + len; idle_from = be + 1;
            end
         end
         e_busy = (n + 1 < idle_from);
         e_txen = enable;
      end
      req0 = 1'b0; req1 = 1'b0; clear_err = 1'b0; baud_cfg_wr = 1'b0; Tx_BUSY = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt;

      // Single request, transmitter busy 2 cycles after the write for 20 cycles.
      do_reset();
      check_reset_vals("rst");
      req0 = 1'b1; data0 = 8'hAA;
      tick();
      check_eq("a_wr", 32'(Tx_WR), 1);
      check_eq("a_ack0", 32'(ack0), 1);
      check_eq("a_ack1", 32'(ack1), 0);
      check_eq("a_data", 32'(Tx_DATA), 32'hAA);
      check_eq("a_grant", 32'(grant), 0);
      check_eq("a_busy", 32'(busy), 1);
      req0 = 1'b0;
      tick();
      check_eq("a_wr_once", 32'(Tx_WR), 0);
      check_eq("a_ack_once", 32'(ack0), 0);
      tick();
      Tx_BUSY = 1'b1;
      for (int i = 0; i < 20; i++) begin
         baud_cfg = 3'd2;
         baud_cfg_wr = (i == 5);
         tick();
      end
      baud_cfg_wr = 1'b0; Tx_BUSY = 1'b0;
      check_eq("a_busy_hold", 32'(busy), 1);
      check_eq("a_baud_ignored", 32'(baud_select), 7);
      tick();
      check_eq("a_busy_low", 32'(busy), 0);
      check_eq("a_data_hold", 32'(Tx_DATA), 32'hAA);
      baud_cfg = 3'd2; baud_cfg_wr = 1'b1;
      tick();
      baud_cfg_wr = 1'b0;
      check_eq("a_baud_load", 32'(baud_select), 2);

      // Both requesters held: strict alternation starting with req0.
      do_reset();
      req0 = 1'b1; req1 = 1'b1; data0 = 8'h55; data1 = 8'hCC;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         tick();
         while (!Tx_WR && n < 20) begin tick(); n++; end
         check_eq("b_seen", 32'(Tx_WR), 1);
         check_eq("b_data", 32'(Tx_DATA), (k % 2 == 0) ? 32'h55 : 32'hCC);
         check_eq("b_ack0", 32'(ack0), (k % 2 == 0) ? 1 : 0);
         check_eq("b_ack1", 32'(ack1), (k % 2 == 1) ? 1 : 0);
         Tx_BUSY = 1'b1;
         tick(); tick();
         Tx_BUSY = 1'b0;
      end
      req0 = 1'b0; req1 = 1'b0;

      // Transmitter never goes busy: timeout, clear, then set-beats-clear.
      do_reset();
      req1 = 1'b1; data1 = 8'h33;
      tick();
      check_eq("c_wr", 32'(Tx_WR), 1);
      check_eq("c_ack1", 32'(ack1), 1);
      req1 = 1'b0;
      cnt = 0;
      for (int i = 1; i <= 16; i++) begin tick(); cnt += int'(Tx_WR); end
      check_eq("c_err_pre", 32'(timeout_err), 0);
      check_eq("c_busy_pre", 32'(busy), 1);
      tick();
      cnt += int'(Tx_WR);
      check_eq("c_err_set", 32'(timeout_err), 1);
      check_eq("c_idle", 32'(busy), 0);
      check_eq("c_wr_count", 32'(cnt), 0);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check_eq("c_err_clr", 32'(timeout_err), 0);
      req1 = 1'b1; data1 = 8'h44; clear_err = 1'b1;
      tick();
      check_eq("c2_wr", 32'(Tx_WR), 1);
      req1 = 1'b0;
      repeat (17) tick();
      check_eq("c2_set_wins", 32'(timeout_err), 1);
      tick();
      check_eq("c2_cleared", 32'(timeout_err), 0);
      clear_err = 1'b0;

      // Enable dropped during WAIT_END with a pending request.
      do_reset();
      req0 = 1'b1; data0 = 8'h11;
      tick();
      check_eq("d_wr", 32'(Tx_WR), 1);
      data0 = 8'h22; Tx_BUSY = 1'b1;
      tick(); tick();
      check_eq("d_txen_pre", 32'(Tx_EN), 1);
      enable = 1'b0;
      tick();
      check_eq("d_idle", 32'(busy), 0);
      check_eq("d_txen_low", 32'(Tx_EN), 0);
      Tx_BUSY = 1'b0;
      cnt = 0;
      repeat (4) begin tick(); cnt += int'(ack0) + int'(Tx_WR); end
      check_eq("d_no_ack", 32'(cnt), 0);
      enable = 1'b1;
      tick();
      check_eq("d_wr2", 32'(Tx_WR), 1);
      check_eq("d_ack2", 32'(ack0), 1);
      check_eq("d_data2", 32'(Tx_DATA), 32'h22);
      check_eq("d_txen_back", 32'(Tx_EN), 1);
      req0 = 1'b0;

      // Asynchronous reset in the middle of WAIT_START.
      do_reset();
      baud_cfg = 3'd3; baud_cfg_wr = 1'b1;
      tick();
      baud_cfg_wr = 1'b0;
      check_eq("e_baud", 32'(baud_select), 3);
      req0 = 1'b1; data0 = 8'h5A;
      tick();
      req0 = 1'b0;
      tick(); tick();
      check_eq("e_busy_pre", 32'(busy), 1);
      check_eq("e_grant_pre", 32'(grant), 0);
      #2 reset = 1'b0;
      #1;
      check_reset_vals("e");
      tick();
      reset = 1'b1;
      tick();
      check_eq("e_post_wr", 32'(Tx_WR), 0);
      check_eq("e_post_ack", 32'(ack0), 0);

      run_random(3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 16: max cycles from Tx_WR pulse to Tx_BUSY assertion.
REQ-002 Parameter BAUD_RESET, default 3'd7: baud_select value after reset.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 enable  in  1  global transmit enable from system control.
REQ-006 req0, req1  in  1 each  requester byte-send requests; held until matching ack.
REQ-007 data0, data1  in  8 each  requester bytes; stable while req high.
REQ-008 ack0, ack1  out  1 each  one-cycle pulse: byte captured and issued.
REQ-009 baud_cfg  in  3  new baud selection.
REQ-010 baud_cfg_wr  in  1  one-cycle strobe to load baud_cfg.
REQ-011 clear_err  in  1  clears timeout_err.
REQ-012 Tx_BUSY  in  1  busy flag from UART transmitter.
REQ-013 Tx_DATA  out  8  byte to UART transmitter.
REQ-014 Tx_WR  out  1  one-cycle write strobe to UART transmitter.
REQ-015 Tx_EN  out  1  UART transmitter enable.
REQ-016 baud_select  out  3  UART baud rate selection.
REQ-017 grant  out  1  index of last issued requester.
REQ-018 busy  out  1  high whenever FSM is not IDLE.
REQ-019 timeout_err  out  1  sticky error: Tx_BUSY never rose after Tx_WR.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT_START, WAIT_END; all outputs registered.
REQ-021 IDLE->ISSUE on the edge where enable=1, Tx_BUSY=0, and (req0|req1)=1; winner's data captured into Tx_DATA on that edge.
REQ-022 ISSUE lasts exactly one cycle: Tx_WR=1, ack of winner=1, grant=winner; next state WAIT_START.
REQ-023 Latency: Tx_WR and ack high in the cycle immediately after the arbitration edge.
REQ-024 Arbitration round-robin: both requesting -> requester opposite to grant wins; single requester always wins.
REQ-025 WAIT_START: 5-bit counter increments each cycle; Tx_BUSY=1 -> WAIT_END; counter reaching BUSY_TIMEOUT with Tx_BUSY=0 -> set timeout_err, go IDLE.
REQ-026 WAIT_END: Tx_BUSY=0 -> IDLE; no timeout in this state.
REQ-027 Minimum spacing between Tx_WR pulses: ISSUE + 1 WAIT_START + 1 WAIT_END + 1 IDLE = 4 cycles.
REQ-028 Tx_EN = enable delayed one cycle.
REQ-029 enable=0 in WAIT_START or WAIT_END -> IDLE on next edge; no ack for pending requests; no timeout_err.
REQ-030 enable=0 while in ISSUE: ISSUE still completes (Tx_WR, ack issued), then REQ-029 applies.
REQ-031 baud_cfg_wr honoured only in IDLE and only when no arbitration occurs on that edge; otherwise ignored (no queueing).
REQ-032 timeout_err cleared by clear_err=1; simultaneous set and clear -> set wins.
REQ-033 Tx_DATA holds last issued byte until next ISSUE.
REQ-034 ack0 and ack1 never high in the same cycle; Tx_WR high only in ISSUE.

Reset
REQ-035 reset=0 asynchronously forces: state IDLE, Tx_WR=0, ack0=ack1=0, Tx_DATA=8'h00, Tx_EN=0, baud_select=BAUD_RESET, grant=1 (req0 wins first tie), busy=0, timeout_err=0, counter=0.
REQ-036 Reset mid-transfer aborts silently; no ack or Tx_WR in the cycle after reset release.

Verification
REQ-037 req0=1, data0=8'hAA, enable=1, Tx_BUSY model rises 2 cycles after Tx_WR, lasts 20 cycles -> Tx_WR+ack0 one cycle, Tx_DATA=8'hAA, grant=0, busy low after Tx_BUSY falls.
REQ-038 req0 and req1 held continuously with 8'h55/8'hCC after reset -> issue order 8'h55, 8'hCC, 8'h55, 8'hCC; ack0/ack1 alternate.
REQ-039 Tx_BUSY tied 0, req1=1 -> Tx_WR once, timeout_err=1 exactly 16 cycles after WAIT_START entry, FSM back to IDLE; clear_err -> timeout_err=0.
REQ-040 baud_cfg=3'd2 with baud_cfg_wr in IDLE -> baud_select=2 next cycle; same strobe during WAIT_END -> baud_select unchanged.
REQ-041 enable dropped during WAIT_END with req0 pending -> IDLE next edge, Tx_EN=0 one cycle later, no ack0 until enable returns.
REQ-042 reset=0 asserted mid-WAIT_START -> all outputs at REQ-035 values immediately, without a clock edge.
